// File: rtl/mac_tx_pkg.sv
// Shared definitions for the egress arbiter: FSM encoding, pointer layout and
// default overhead figures used by the guard-band fit check.
package mac_tx_pkg;

    localparam int unsigned PTR_W       = 16;
    localparam int unsigned LEN_MSB     = 10;
    localparam int unsigned OVH_DEF     = 12;
    localparam int unsigned IFG_DEF     = 12;
    localparam int unsigned MIN_LEN_DEF = 60;

    localparam logic [15:0] NONE_SCHED  = 16'hFFFF;

    typedef enum logic [5:0] {
        StIdle  = 6'b000001,
        StRdptr = 6'b000010,
        StLatch = 6'b000100,
        StChk   = 6'b001000,
        StData  = 6'b010000,
        StFlush = 6'b100000
    } arb_state_e;

endpackage

// File: rtl/mac_tx_guard.sv
// Guard-band fit check: does a normal frame, with all wire overhead, finish
// before the next time-triggered window opens?
module mac_tx_guard import mac_tx_pkg::*; #(
    parameter bit          GUARD_EN = 1'b1,
    parameter int unsigned IFG      = IFG_DEF,
    parameter int unsigned OVH      = OVH_DEF,
    parameter int unsigned MIN_LEN  = MIN_LEN_DEF
) (
    input  logic [LEN_MSB:0] len,
    input  logic             tt_gate,
    input  logic [15:0]      tt_next_cnt,
    output logic             fit
);

    localparam logic [15:0] MinLen = 16'(MIN_LEN);
    localparam logic [15:0] Extra  = 16'(OVH + IFG);

    logic [15:0] len_ext;
    logic [15:0] body;
    logic [15:0] need;

    // Short frames occupy the wire for MIN_LEN bytes once the MAC pads them.
    always_comb begin
        len_ext = {{(15 - LEN_MSB){1'b0}}, len};
        body    = (len_ext < MinLen) ? MinLen : len_ext;
        need    = body + Extra;
        fit     = !tt_gate &&
                  (!GUARD_EN || (tt_next_cnt == NONE_SCHED) || (tt_next_cnt >= need));
    end

endmodule

// File: rtl/mac_tx_arb.sv
// Egress arbiter: merges the TTE and normal frame queues into one pointer/byte
// stream for the MAC, with strict TTE priority and a guard band for normal frames.
module mac_tx_arb import mac_tx_pkg::*; #(
    parameter bit          GUARD_EN = 1'b1,
    parameter int unsigned IFG      = IFG_DEF,
    parameter int unsigned OVH      = OVH_DEF,
    parameter int unsigned MIN_LEN  = MIN_LEN_DEF
) (
    input  logic              sys_clk,
    input  logic              rstn,
    output logic              ptr_fifo_rd,
    input  logic [PTR_W-1:0]  ptr_fifo_din,
    input  logic              ptr_fifo_empty,
    output logic              data_fifo_rd,
    input  logic [7:0]        data_fifo_din,
    output logic              tptr_fifo_rd,
    input  logic [PTR_W-1:0]  tptr_fifo_din,
    input  logic              tptr_fifo_empty,
    output logic              tdata_fifo_rd,
    input  logic [7:0]        tdata_fifo_din,
    input  logic              tt_gate,
    input  logic [15:0]       tt_next_cnt,
    input  logic              out_bp,
    output logic              out_ptr_wr,
    output logic [PTR_W-1:0]  out_ptr,
    output logic              out_data_wr,
    output logic [7:0]        out_data,
    output logic              arb_dir,
    output logic              busy
);

    arb_state_e       state_q, state_d;
    logic             dir_q, dir_d;
    logic             pend_v_q, pend_v_d;
    logic [PTR_W-1:0] cur_ptr_q, cur_ptr_d;
    logic [PTR_W-1:0] pend_ptr_q, pend_ptr_d;
    logic [LEN_MSB:0] cnt_q, cnt_d;
    logic             ptr_sent_q, ptr_sent_d;
    logic             out_data_wr_q;
    logic             byte_rd;
    logic             fit;

    mac_tx_guard #(
        .GUARD_EN (GUARD_EN),
        .IFG      (IFG),
        .OVH      (OVH),
        .MIN_LEN  (MIN_LEN)
    ) u_guard (
        .len         (cur_ptr_q[LEN_MSB:0]),
        .tt_gate     (tt_gate),
        .tt_next_cnt (tt_next_cnt),
        .fit         (fit)
    );

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        pend_v_d     = pend_v_q;
        cur_ptr_d    = cur_ptr_q;
        pend_ptr_d   = pend_ptr_q;
        cnt_d        = cnt_q;
        ptr_sent_d   = ptr_sent_q;
        ptr_fifo_rd  = 1'b0;
        tptr_fifo_rd = 1'b0;
        byte_rd      = 1'b0;
        out_ptr_wr   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!out_bp) begin
                    if (!tptr_fifo_empty) begin
                        dir_d   = 1'b1;
                        state_d = StRdptr;
                    end else if (pend_v_q) begin
                        // Held pointer lives apart from cur_ptr so a TTE frame
                        // served in between cannot overwrite it.
                        dir_d     = 1'b0;
                        cur_ptr_d = pend_ptr_q;
                        state_d   = StChk;
                    end else if (!ptr_fifo_empty && !tt_gate) begin
                        dir_d   = 1'b0;
                        state_d = StRdptr;
                    end
                end
            end
            StRdptr: begin
                tptr_fifo_rd = dir_q;
                ptr_fifo_rd  = !dir_q;
                state_d      = StLatch;
            end
            StLatch: begin
                cur_ptr_d = dir_q ? tptr_fifo_din : ptr_fifo_din;
                if (!dir_q) begin
                    pend_v_d   = 1'b1;
                    pend_ptr_d = ptr_fifo_din;
                end
                state_d = StChk;
            end
            StChk: begin
                if (dir_q || fit) begin
                    if (!dir_q) begin
                        pend_v_d = 1'b0;
                    end
                    cnt_d      = cur_ptr_q[LEN_MSB:0];
                    ptr_sent_d = 1'b0;
                    state_d    = StData;
                end else begin
                    state_d = StIdle;
                end
            end
            StData: begin
                out_ptr_wr = !ptr_sent_q;
                ptr_sent_d = 1'b1;
                if (cnt_q != '0) begin
                    byte_rd = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                end
                if (cnt_q <= 11'd1) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q       <= StIdle;
            dir_q         <= 1'b0;
            pend_v_q      <= 1'b0;
            cur_ptr_q     <= '0;
            pend_ptr_q    <= '0;
            cnt_q         <= '0;
            ptr_sent_q    <= 1'b0;
            out_data_wr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            pend_v_q      <= pend_v_d;
            cur_ptr_q     <= cur_ptr_d;
            pend_ptr_q    <= pend_ptr_d;
            cnt_q         <= cnt_d;
            ptr_sent_q    <= ptr_sent_d;
            out_data_wr_q <= byte_rd;
        end
    end

    // Source din is valid the cycle after the strobe, so the byte write lines
    // up with the delayed strobe and takes din straight through.
    always_comb begin
        data_fifo_rd  = byte_rd && !dir_q;
        tdata_fifo_rd = byte_rd && dir_q;
        out_ptr       = out_ptr_wr ? cur_ptr_q : '0;
        out_data_wr   = out_data_wr_q;
        out_data      = out_data_wr_q ? (dir_q ? tdata_fifo_din : data_fifo_din) : 8'h00;
        arb_dir       = dir_q;
        busy          = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mac_tx_arb.sv
// Bench for mac_tx_arb: FIFO source models, an output monitor and a frame-level
// reference (expected order, bytes, timing and guard-band decisions).
module tb_mac_tx_arb;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic        ptr_fifo_rd, data_fifo_rd, tptr_fifo_rd, tdata_fifo_rd;
    logic [15:0] ptr_fifo_din = '0, tptr_fifo_din = '0;
    logic [7:0]  data_fifo_din = '0, tdata_fifo_din = '0;
    logic        ptr_fifo_empty, tptr_fifo_empty;
    logic        tt_gate, out_bp;
    logic [15:0] tt_next_cnt;
    logic        out_ptr_wr, out_data_wr, arb_dir, busy;
    logic [15:0] out_ptr;
    logic [7:0]  out_data;

    mac_tx_arb dut (
        .sys_clk         (sys_clk),
        .rstn            (rstn),
        .ptr_fifo_rd     (ptr_fifo_rd),
        .ptr_fifo_din    (ptr_fifo_din),
        .ptr_fifo_empty  (ptr_fifo_empty),
        .data_fifo_rd    (data_fifo_rd),
        .data_fifo_din   (data_fifo_din),
        .tptr_fifo_rd    (tptr_fifo_rd),
        .tptr_fifo_din   (tptr_fifo_din),
        .tptr_fifo_empty (tptr_fifo_empty),
        .tdata_fifo_rd   (tdata_fifo_rd),
        .tdata_fifo_din  (tdata_fifo_din),
        .tt_gate         (tt_gate),
        .tt_next_cnt     (tt_next_cnt),
        .out_bp          (out_bp),
        .out_ptr_wr      (out_ptr_wr),
        .out_ptr         (out_ptr),
        .out_data_wr     (out_data_wr),
        .out_data        (out_data),
        .arb_dir         (arb_dir),
        .busy            (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Source FIFO models: the bench writes the *_wr indices, the model reads.
    logic [15:0] nptr_mem [64];
    logic [15:0] tptr_mem [64];
    logic [7:0]  ndat_mem [8192];
    logic [7:0]  tdat_mem [8192];
    int nptr_wr = 0, nptr_rd = 0, tptr_wr = 0, tptr_rd = 0;
    int ndat_wr = 0, ndat_rd = 0, tdat_wr = 0, tdat_rd = 0;

    assign ptr_fifo_empty  = (nptr_wr == nptr_rd);
    assign tptr_fifo_empty = (tptr_wr == tptr_rd);

    always @(posedge sys_clk) begin
        if (!rstn) begin
            nptr_rd <= nptr_wr;
            tptr_rd <= tptr_wr;
            ndat_rd <= ndat_wr;
            tdat_rd <= tdat_wr;
        end else begin
            if (ptr_fifo_rd) begin
                ptr_fifo_din <= nptr_mem[nptr_rd % 64];
                nptr_rd      <= nptr_rd + 1;
            end
            if (tptr_fifo_rd) begin
                tptr_fifo_din <= tptr_mem[tptr_rd % 64];
                tptr_rd       <= tptr_rd + 1;
            end
            if (data_fifo_rd) begin
                data_fifo_din <= ndat_mem[ndat_rd % 8192];
                ndat_rd       <= ndat_rd + 1;
            end
            if (tdata_fifo_rd) begin
                tdata_fifo_din <= tdat_mem[tdat_rd % 8192];
                tdat_rd        <= tdat_rd + 1;
            end
        end
    end

    // Output monitor
    logic [15:0] got_ptr [$];
    int          got_pcyc [$];
    bit          got_dir [$];
    logic [7:0]  got_data [$];
    int          got_dcyc [$];
    int n_prd = 0, n_tprd = 0, n_drd = 0, n_tdrd = 0, last_busy = 0;

    always @(negedge sys_clk) begin
        if (out_ptr_wr === 1'b1) begin
            got_ptr.push_back(out_ptr);
            got_pcyc.push_back(cyc);
            got_dir.push_back(arb_dir);
        end
        if (out_data_wr === 1'b1) begin
            got_data.push_back(out_data);
            got_dcyc.push_back(cyc);
        end
        if (ptr_fifo_rd === 1'b1) n_prd++;
        if (tptr_fifo_rd === 1'b1) n_tprd++;
        if (data_fifo_rd === 1'b1) n_drd++;
        if (tdata_fifo_rd === 1'b1) n_tdrd++;
        if (busy === 1'b1) last_busy = cyc;
    end

    // Frame registry: what was queued, for the reference side.
    logic [15:0] fr_ptr [64];
    int          fr_off [64];
    int          fr_len [64];
    bit          fr_tte [64];
    int          n_fr = 0;
    logic [7:0]  exp_bytes [$];

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    function automatic bit model_fit(input int len, input int cnt, input bit gate);
        int need;
        need = ((len < 60) ? 60 : len) + 12 + 12;
        return !gate && (cnt == 'hFFFF || cnt >= need);
    endfunction

    task automatic push_frame(input bit tte, input int len, output int id);
        logic [15:0] p;
        logic [7:0]  b;
        p = {5'($urandom), 11'(len)};
        id = n_fr;
        n_fr++;
        fr_ptr[id % 64] = p;
        fr_len[id % 64] = len;
        fr_tte[id % 64] = tte;
        fr_off[id % 64] = exp_bytes.size();
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            exp_bytes.push_back(b);
            if (tte) begin
                tdat_mem[tdat_wr % 8192] = b;
                tdat_wr++;
            end else begin
                ndat_mem[ndat_wr % 8192] = b;
                ndat_wr++;
            end
        end
        if (tte) begin
            tptr_mem[tptr_wr % 64] = p;
            tptr_wr++;
        end else begin
            nptr_mem[nptr_wr % 64] = p;
            nptr_wr++;
        end
    endtask

    task automatic wait_done(input string tag, input int np, input int nd, input int budget);
        int n;
        n = 0;
        while (!(got_ptr.size() >= np && got_data.size() >= nd && busy === 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " completes"}, 32'(n < budget), 1);
    endtask

    // exp_pc < 0 skips the absolute pointer-write cycle check.
    task automatic chk_frame(input string tag, input int id, input int pi, input int di,
                             input int exp_pc);
        int errs, len, k;
        k    = id % 64;
        len  = fr_len[k];
        errs = 0;
        if (got_ptr.size() <= pi) begin
            chk({tag, " ptr_count"}, got_ptr.size(), pi + 1);
            return;
        end
        chk({tag, " ptr"}, 32'(got_ptr[pi]), 32'(fr_ptr[k]));
        chk({tag, " dir"}, 32'(got_dir[pi]), 32'(fr_tte[k]));
        if (exp_pc >= 0) chk({tag, " ptr_cyc"}, got_pcyc[pi], exp_pc);
        for (int j = 0; j < len; j++) begin
            if (di + j >= got_data.size()) errs++;
            else if (got_data[di + j] !== exp_bytes[fr_off[k] + j]) errs++;
        end
        chk({tag, " bytes"}, errs, 0);
        if (len > 0 && di + len - 1 < got_data.size()) begin
            chk({tag, " first_byte_cyc"}, got_dcyc[di], got_pcyc[pi] + 1);
            chk({tag, " last_byte_cyc"}, got_dcyc[di + len - 1], got_pcyc[pi] + len);
        end
    endtask

    task automatic fit_case(input string tag, input int len, input int cnt);
        int id, pi, di;
        bit exp;
        exp = model_fit(len, cnt, 1'b0);
        pi  = got_ptr.size();
        di  = got_data.size();
        tt_next_cnt = 16'(cnt);
        push_frame(1'b0, len, id);
        repeat (20) tick();
        chk({tag, " started"}, got_ptr.size() - pi, 32'(exp));
        chk({tag, " data_rd_seen"}, 32'(got_data.size() > di), 32'(exp));
        tt_next_cnt = 16'hFFFF;
        wait_done(tag, pi + 1, di + len, len + 100);
        chk_frame(tag, id, pi, di, -1);
    endtask

    function automatic logic [31:0] out_vec();
        return {8'(out_ptr >> 8), out_ptr[7:0], out_data,
                ptr_fifo_rd, data_fifo_rd, tptr_fifo_rd, tdata_fifo_rd,
                out_ptr_wr, out_data_wr, arb_dir, busy};
    endfunction

    initial begin
        int id, id2, pi, di, m, p0, d0, t0, len, len2, need;
        rstn        = 1'b0;
        out_bp      = 1'b0;
        tt_gate     = 1'b0;
        tt_next_cnt = 16'hFFFF;
        repeat (3) tick();
        chk("reset outputs", out_vec(), 0);
        rstn = 1'b1;
        repeat (2) tick();

        // Single TTE frame, len 64
        pi = got_ptr.size(); di = got_data.size(); t0 = n_tdrd;
        push_frame(1'b1, 64, id);
        m = cyc;
        wait_done("tte64", pi + 1, di + 64, 200);
        chk_frame("tte64", id, pi, di, m + 4);
        chk("tte64 tdata_rd count", n_tdrd - t0, 64);
        chk("tte64 idle_cyc", last_busy + 1, m + 69);

        // Both queues non-empty at once: TTE first, normal right after
        len  = $urandom_range(20, 80);
        len2 = $urandom_range(20, 80);
        pi = got_ptr.size(); di = got_data.size(); p0 = n_prd;
        push_frame(1'b1, len, id);
        push_frame(1'b0, len2, id2);
        m = cyc;
        wait_done("both", pi + 2, di + len + len2, 500);
        chk_frame("both tte", id, pi, di, m + 4);
        chk_frame("both norm", id2, pi + 1, di + len, m + len + 9);
        chk("both ptr_rd", n_prd - p0, 1);

        // Long normal frame held by the guard band, then released
        pi = got_ptr.size(); di = got_data.size(); p0 = n_prd; d0 = n_drd;
        tt_next_cnt = 16'd1000;
        push_frame(1'b0, 1500, id);
        repeat (40) tick();
        chk("held1500 no ptr_wr", got_ptr.size(), pi);
        chk("held1500 no data_rd", n_drd - d0, 0);
        chk("held1500 ptr_rd once", n_prd - p0, 1);
        chk("held1500 model", 32'(model_fit(1500, 1000, 1'b0)), 0);
        tt_next_cnt = 16'hFFFF;
        wait_done("rel1500", pi + 1, di + 1500, 1700);
        chk_frame("rel1500", id, pi, di, -1);
        chk("rel1500 no reread", n_prd - p0, 1);
        chk("rel1500 data_rd", n_drd - d0, 1500);

        // Guard-band boundary and randomized fit decisions
        fit_case("fit10_84", 10, 84);
        fit_case("fit10_83", 10, 83);
        for (int i = 0; i < 4; i++) begin
            len  = $urandom_range(1, 300);
            need = ((len < 60) ? 60 : len) + 24;
            fit_case($sformatf("fitrnd%0d", i), len, need + $urandom_range(0, 4) - 2);
        end

        // Zero-length frame
        pi = got_ptr.size(); di = got_data.size(); t0 = n_tdrd;
        push_frame(1'b1, 0, id);
        m = cyc;
        wait_done("len0", pi + 1, di, 50);
        chk_frame("len0", id, pi, di, m + 4);
        chk("len0 no byte rd", n_tdrd - t0, 0);
        chk("len0 no byte wr", got_data.size(), di);

        // tt_gate blocks a normal start but not TTE
        tt_gate = 1'b1;
        pi = got_ptr.size(); di = got_data.size(); p0 = n_prd;
        push_frame(1'b0, 16, id2);
        repeat (20) tick();
        chk("gate no ptr_rd", n_prd - p0, 0);
        push_frame(1'b1, 8, id);
        wait_done("gate tte", pi + 1, di + 8, 60);
        chk_frame("gate tte", id, pi, di, -1);
        chk("gate norm still queued", n_prd - p0, 0);
        tt_gate = 1'b0;
        wait_done("gate norm", pi + 2, di + 24, 100);
        chk_frame("gate norm", id2, pi + 1, di + 8, -1);

        // Reset during DATA drops the frame and the held pointer
        tt_next_cnt = 16'd1000;
        push_frame(1'b0, 1500, id2);
        repeat (10) tick();
        push_frame(1'b1, 200, id);
        m = cyc;
        while (cyc < m + 20) tick();
        chk("mid-frame tdata_rd", 32'(tdata_fifo_rd), 1);
        rstn = 1'b0;
        tick();
        chk("mid-frame reset outputs", out_vec(), 0);
        rstn = 1'b1;
        tt_next_cnt = 16'hFFFF;
        pi = got_ptr.size();
        repeat (30) tick();
        chk("reset drops pend", got_ptr.size(), pi);
        chk("reset idle", 32'(busy), 0);

        // Back-pressure blocks a start, never a frame in flight
        out_bp = 1'b1;
        pi = got_ptr.size(); di = got_data.size();
        push_frame(1'b1, 30, id);
        repeat (15) tick();
        chk("bp blocks start", got_ptr.size(), pi);
        chk("bp idle", 32'(busy), 0);
        out_bp = 1'b0;
        m = cyc;
        repeat (6) tick();
        out_bp = 1'b1;
        wait_done("bp inflight", pi + 1, di + 30, 80);
        chk_frame("bp inflight", id, pi, di, m + 4);
        out_bp = 1'b0;

        // Randomized single frames from either queue
        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(1, 120);
            pi = got_ptr.size(); di = got_data.size();
            push_frame(1'($urandom), len, id);
            m = cyc;
            wait_done($sformatf("rnd%0d", i), pi + 1, di + len, len + 40);
            chk_frame($sformatf("rnd%0d", i), id, pi, di, m + 4);
            chk($sformatf("rnd%0d idle_cyc", i), last_busy + 1, m + len + 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
